// File: rtl/icache_s2_pkg.sv
// Shared cache definitions for the two-stage instruction cache.
// Bus typedefs, address field widths, the refill FSM state codes, and a
// helper that extracts one 32-bit bank word from a 256-bit cache line.
package icache_s2_pkg;

  localparam int BANK_NUM        = 8;
  localparam int TAG_W           = 21;
  localparam int LINE_W          = BANK_NUM * 32;
  localparam int ICACHE_STATUS_W = 2;

  typedef logic [31:0]       DataAddrBus;  // data word / address
  typedef logic [LINE_W-1:0] WayBus;       // one full cache line
  typedef logic [TAG_W-1:0]  TagBus;       // PA[31:11]
  typedef logic [5:0]        IndexBus;     // PA[10:5]
  typedef logic [2:0]        BankBus;      // PA[4:2]

  typedef enum logic [ICACHE_STATUS_W-1:0] {
    ICACHE_IDLE     = 2'd0,
    ICACHE_READ     = 2'd1,
    ICACHE_UNCACHED = 2'd2,
    ICACHE_DONE     = 2'd3
  } icache_status_e;

  // Word 'bank' of a line occupies bits [32*bank+31 : 32*bank].
  function automatic DataAddrBus line_word(input WayBus line, input BankBus bank);
    return line[{bank, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/icache_s2_tag_cmp.sv
// Per-way hit detector.
// Ports: en (lookup enabled), valid (way valid bit), way_tag (stored tag),
//        pa_tag (PA[31:11]), hit (way hit).
module icache_s2_tag_cmp
  import icache_s2_pkg::*;
(
  input  logic  en,
  input  logic  valid,
  input  TagBus way_tag,
  input  TagBus pa_tag,
  output logic  hit
);

  assign hit = en & valid & (way_tag == pa_tag);

endmodule

// File: rtl/icache_s2.sv
// Instruction cache stage 2: tag compare, hit-word select and AXI refill FSM.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s2_*_i                        registered request, tags, valids, bank words from stage 1
//   cpu_stall_i, flush_i          downstream stall, request kill
//   rend_i, cacheline_rdata_i     AXI read completion and returned line
//   rd_req_o/rd_addr_o/rd_uncached_o  AXI read request (level until rend_i)
//   s2_hit1_o/s2_hit2_o/s2_rreq_o/s2_status_o  feedback to stage 1
//   icache_stall_o                stall stage 1 and the PC
//   inst_o/inst_valid_o/inst_addr_o  instruction to the fetch pipeline
module icache_s2
  import icache_s2_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s2_virtual_addr_i,
  input  logic [31:0] s2_physical_addr_i,
  input  logic        s2_en_i,
  input  logic        s2_cache_rreq_i,
  input  logic        s2_cached_i,
  input  logic        s2_install_i,
  input  logic [20:0] s2_tagv_w0_i,
  input  logic [20:0] s2_tagv_w1_i,
  input  logic        s2_valid0_i,
  input  logic        s2_valid1_i,
  input  logic [31:0] s2_data_way0_i,
  input  logic [31:0] s2_data_way1_i,
  input  logic        cpu_stall_i,
  input  logic        flush_i,
  input  logic        rend_i,
  input  logic [255:0] cacheline_rdata_i,
  output logic        rd_req_o,
  output logic [31:0] rd_addr_o,
  output logic        rd_uncached_o,
  output logic        s2_hit1_o,
  output logic        s2_hit2_o,
  output logic        s2_rreq_o,
  output logic [1:0]  s2_status_o,
  output logic        icache_stall_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic [31:0] inst_addr_o
);

  icache_status_e state_r, state_nxt_s;

  logic       lookup_en_s;
  logic       hit0_raw_s, hit1_raw_s;
  logic       hit0_sel_s, hit1_sel_s, hit_any_s;
  DataAddrBus word_sram_s, word_sel_s;

  logic       hit0_save_r, hit1_save_r;
  DataAddrBus word_save_r;
  DataAddrBus refill_word_r;
  logic       flushed_r;

  assign lookup_en_s = s2_cache_rreq_i & (state_r == ICACHE_IDLE);

  icache_s2_tag_cmp u_cmp_w0 (
    .en      (lookup_en_s),
    .valid   (s2_valid0_i),
    .way_tag (s2_tagv_w0_i),
    .pa_tag  (s2_physical_addr_i[31:11]),
    .hit     (hit0_raw_s)
  );

  icache_s2_tag_cmp u_cmp_w1 (
    .en      (lookup_en_s),
    .valid   (s2_valid1_i),
    .way_tag (s2_tagv_w1_i),
    .pa_tag  (s2_physical_addr_i[31:11]),
    .hit     (hit1_raw_s)
  );

  // When the SRAM outputs are stale (stage 1 was stalled) the values captured
  // on the last fresh cycle are used. Way0 wins if both ways report a hit.
  assign word_sram_s = hit0_raw_s ? s2_data_way0_i : s2_data_way1_i;
  assign hit0_sel_s  = s2_install_i ? hit0_save_r : hit0_raw_s;
  assign hit1_sel_s  = (s2_install_i ? hit1_save_r : hit1_raw_s) & ~hit0_sel_s;
  assign word_sel_s  = s2_install_i ? word_save_r : word_sram_s;
  assign hit_any_s   = hit0_sel_s | hit1_sel_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ICACHE_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture hit flags and hit word while the SRAM outputs are fresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit0_save_r <= 1'b0;
      hit1_save_r <= 1'b0;
      word_save_r <= 32'h0000_0000;
    end else if ((state_r == ICACHE_IDLE) && !s2_install_i) begin
      hit0_save_r <= hit0_raw_s;
      hit1_save_r <= hit1_raw_s & ~hit0_raw_s;
      word_save_r <= word_sram_s;
    end
  end

  // Refill word capture and flushed flag; a flush never cancels the AXI read.
  always_ff @(posedge clk) begin
    if (rst) begin
      refill_word_r <= 32'h0000_0000;
      flushed_r     <= 1'b0;
    end else begin
      if (rend_i && (state_r == ICACHE_READ)) begin
        refill_word_r <= line_word(cacheline_rdata_i, s2_virtual_addr_i[4:2]);
      end else if (rend_i && (state_r == ICACHE_UNCACHED)) begin
        refill_word_r <= cacheline_rdata_i[31:0];
      end
      if (((state_r == ICACHE_READ) || (state_r == ICACHE_UNCACHED)) && flush_i) begin
        flushed_r <= 1'b1;
      end else if ((state_r == ICACHE_DONE) && !cpu_stall_i) begin
        flushed_r <= 1'b0;
      end
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt_s    = state_r;
    rd_req_o       = 1'b0;
    rd_addr_o      = 32'h0000_0000;
    rd_uncached_o  = 1'b0;
    s2_hit1_o      = 1'b0;
    s2_hit2_o      = 1'b0;
    s2_rreq_o      = 1'b0;
    icache_stall_o = 1'b0;
    inst_o         = 32'h0000_0000;
    inst_valid_o   = 1'b0;
    case (state_r)
      ICACHE_IDLE: begin
        s2_rreq_o = s2_cache_rreq_i;
        s2_hit1_o = hit0_sel_s;
        s2_hit2_o = hit1_sel_s;
        if (hit_any_s) begin
          inst_o       = word_sel_s;
          inst_valid_o = ~flush_i;
        end else begin
          inst_o       = 32'h0000_0000;
        end
        if (s2_en_i && !hit_any_s && !flush_i) begin
          icache_stall_o = 1'b1;
          if (!cpu_stall_i) begin
            state_nxt_s = s2_cached_i ? ICACHE_READ : ICACHE_UNCACHED;
          end else begin
            state_nxt_s = ICACHE_IDLE;
          end
        end else begin
          state_nxt_s = ICACHE_IDLE;
        end
      end
      ICACHE_READ: begin
        rd_req_o       = 1'b1;
        rd_addr_o      = {s2_physical_addr_i[31:5], 5'b00000};
        s2_rreq_o      = 1'b1;
        icache_stall_o = 1'b1;
        if (rend_i) begin
          state_nxt_s = ICACHE_DONE;
        end else begin
          state_nxt_s = ICACHE_READ;
        end
      end
      ICACHE_UNCACHED: begin
        rd_req_o       = 1'b1;
        rd_addr_o      = s2_physical_addr_i;
        rd_uncached_o  = 1'b1;
        icache_stall_o = 1'b1;
        if (rend_i) begin
          state_nxt_s = ICACHE_DONE;
        end else begin
          state_nxt_s = ICACHE_UNCACHED;
        end
      end
      ICACHE_DONE: begin
        inst_o       = refill_word_r;
        inst_valid_o = ~flushed_r;
        if (cpu_stall_i) begin
          state_nxt_s = ICACHE_DONE;
        end else begin
          state_nxt_s = ICACHE_IDLE;
        end
      end
      default: begin
        state_nxt_s = ICACHE_IDLE;
      end
    endcase
  end

  assign s2_status_o = state_r;
  assign inst_addr_o = s2_virtual_addr_i;

endmodule

// File: tb/tb_icache_s2.sv
module tb_icache_s2;
  import icache_s2_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  s2_virtual_addr_i, s2_physical_addr_i;
  logic         s2_en_i, s2_cache_rreq_i, s2_cached_i, s2_install_i;
  logic [20:0]  s2_tagv_w0_i, s2_tagv_w1_i;
  logic         s2_valid0_i, s2_valid1_i;
  logic [31:0]  s2_data_way0_i, s2_data_way1_i;
  logic         cpu_stall_i, flush_i, rend_i;
  logic [255:0] cacheline_rdata_i;
  logic         rd_req_o, rd_uncached_o, s2_hit1_o, s2_hit2_o, s2_rreq_o;
  logic [31:0]  rd_addr_o, inst_o, inst_addr_o;
  logic [1:0]   s2_status_o;
  logic         icache_stall_o, inst_valid_o;

  always #5 clk = ~clk;

  icache_s2 dut (
    .clk(clk), .rst(rst),
    .s2_virtual_addr_i(s2_virtual_addr_i), .s2_physical_addr_i(s2_physical_addr_i),
    .s2_en_i(s2_en_i), .s2_cache_rreq_i(s2_cache_rreq_i), .s2_cached_i(s2_cached_i),
    .s2_install_i(s2_install_i),
    .s2_tagv_w0_i(s2_tagv_w0_i), .s2_tagv_w1_i(s2_tagv_w1_i),
    .s2_valid0_i(s2_valid0_i), .s2_valid1_i(s2_valid1_i),
    .s2_data_way0_i(s2_data_way0_i), .s2_data_way1_i(s2_data_way1_i),
    .cpu_stall_i(cpu_stall_i), .flush_i(flush_i), .rend_i(rend_i),
    .cacheline_rdata_i(cacheline_rdata_i),
    .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_uncached_o(rd_uncached_o),
    .s2_hit1_o(s2_hit1_o), .s2_hit2_o(s2_hit2_o), .s2_rreq_o(s2_rreq_o),
    .s2_status_o(s2_status_o), .icache_stall_o(icache_stall_o),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o), .inst_addr_o(inst_addr_o)
  );

  typedef struct packed { logic [31:0] word; logic [31:0] addr; } exp_t;
  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  // Model of what stage 1 holds: tag/valid per index and way. Line contents
  // always equal backing memory, so data is derived from mem_word().
  logic [20:0] tag_m   [64][2];
  logic        valid_m [64][2];

  logic [20:0] tag_pool [4] = '{21'h00002, 21'h3F800, 21'h0ABCD, 21'h12345};
  logic [5:0]  idx_pool [2] = '{6'd1, 6'd17};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w ^ 32'h5A5A_C3C3) * 32'h0001_0003 + 32'd1;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_status(input string name, input icache_status_e exp);
    chk32(name, {30'd0, s2_status_o}, {30'd0, exp});
  endtask

  // Monitor: the fetch pipeline accepts an instruction when valid and not stalled.
  always @(negedge clk) begin
    if (!rst && inst_valid_o && !cpu_stall_i) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_inst: got %h addr %h expected none", inst_o, inst_addr_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk32("inst_o", inst_o, e.word);
        chk32("inst_addr_o", inst_addr_o, e.addr);
      end
    end
  end

  task automatic idle_inputs();
    s2_en_i = 1'b0; s2_cache_rreq_i = 1'b0; s2_cached_i = 1'b0;
    s2_install_i = 1'b0; flush_i = 1'b0; rend_i = 1'b0; cpu_stall_i = 1'b0;
  endtask

  // Drive the tag/valid/data that stage 1 would present for this lookup.
  task automatic present(input logic [5:0] idx, input logic [2:0] bank, input logic [20:0] tag);
    for (int w = 0; w < 2; w++) begin
      logic [20:0] t;
      logic        v;
      logic [31:0] d;
      v = valid_m[idx][w];
      if (v) begin
        t = tag_m[idx][w];
        d = mem_word({t, idx, bank, 2'b00});
      end else begin
        t = ($urandom_range(0, 1) == 1) ? tag : 21'($urandom);
        d = $urandom;
      end
      if (w == 0) begin
        s2_tagv_w0_i = t; s2_valid0_i = v; s2_data_way0_i = d;
      end else begin
        s2_tagv_w1_i = t; s2_valid1_i = v; s2_data_way1_i = d;
      end
    end
  endtask

  // One fetch request. d_in<0 picks a random AXI latency; flush_at<0 = no refill flush.
  task automatic do_txn(input logic [31:0] pa, input logic cached, input logic flush_idle,
                        input int flush_at, input logic stall_done, input int d_in);
    logic [20:0]  tag;
    logic [5:0]   idx;
    logic [2:0]   bank;
    logic [31:0]  va;
    logic         hw0, hw1, hit, flushed;
    logic [255:0] line;
    int           d, way;
    exp_t         e;
    tag  = pa[31:11]; idx = pa[10:5]; bank = pa[4:2];
    va   = pa ^ 32'hA000_0000;
    hw0  = cached && valid_m[idx][0] && (tag_m[idx][0] == tag);
    hw1  = cached && valid_m[idx][1] && (tag_m[idx][1] == tag);
    hit  = hw0 || hw1;
    e.word = mem_word(pa);
    e.addr = va;
    @(posedge clk); #1;
    s2_en_i = 1'b1; s2_cache_rreq_i = cached; s2_cached_i = cached;
    s2_physical_addr_i = pa; s2_virtual_addr_i = va;
    flush_i = flush_idle; s2_install_i = 1'b0; cpu_stall_i = 1'b0;
    present(idx, bank, tag);
    if (hit) begin
      if (!flush_idle) exp_q.push_back(e);
      @(negedge clk);
      chk1("hit_stall", icache_stall_o, 1'b0);
      chk1("hit1", s2_hit1_o, hw0);
      chk1("hit2", s2_hit2_o, hw1 && !hw0);
      chk1("hit_rd_req", rd_req_o, 1'b0);
      @(posedge clk); #1;
      idle_inputs();
    end else if (flush_idle) begin
      @(negedge clk);
      chk1("flush_stall", icache_stall_o, 1'b0);
      chk1("flush_valid", inst_valid_o, 1'b0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      chk_status("flush_status", ICACHE_IDLE);
      chk1("flush_rd_req", rd_req_o, 1'b0);
    end else begin
      @(negedge clk);
      chk1("miss_stall", icache_stall_o, 1'b1);
      chk1("miss_valid", inst_valid_o, 1'b0);
      d = (d_in < 0) ? $urandom_range(0, 3) : d_in;
      flushed = (flush_at >= 0) && (flush_at <= d);
      for (int i = 0; i < 8; i++) begin
        line[32*i +: 32] = cached ? mem_word({pa[31:5], 3'(i), 2'b00}) : $urandom;
      end
      if (!cached) line[31:0] = mem_word(pa);
      if (!flushed) exp_q.push_back(e);
      for (int k = 0; k <= d; k++) begin
        @(posedge clk); #1;
        flush_i = (k == flush_at);
        rend_i  = (k == d);
        for (int i = 0; i < 8; i++) cacheline_rdata_i[32*i +: 32] = $urandom;
        if (rend_i) cacheline_rdata_i = line;
        @(negedge clk);
        chk1("rd_req", rd_req_o, 1'b1);
        chk32("rd_addr", rd_addr_o, cached ? {pa[31:5], 5'b00000} : pa);
        chk1("rd_uncached", rd_uncached_o, !cached);
        chk_status("refill_status", cached ? ICACHE_READ : ICACHE_UNCACHED);
        chk1("refill_rreq", s2_rreq_o, cached);
        chk1("refill_hits", s2_hit1_o | s2_hit2_o, 1'b0);
        chk1("refill_stall", icache_stall_o, 1'b1);
      end
      @(posedge clk); #1;
      idle_inputs();
      cpu_stall_i = stall_done;
      if (cached) begin
        if (!valid_m[idx][0]) way = 0;
        else if (!valid_m[idx][1]) way = 1;
        else way = $urandom_range(0, 1);
        valid_m[idx][way] = 1'b1;
        tag_m[idx][way]   = tag;
      end
      @(negedge clk);
      chk_status("done_status", ICACHE_DONE);
      chk1("done_valid", inst_valid_o, !flushed);
      chk1("done_stall", icache_stall_o, 1'b0);
      chk1("done_rd_req", rd_req_o, 1'b0);
      if (stall_done) begin
        @(posedge clk); #1;
        cpu_stall_i = 1'b0;
        @(negedge clk);
        chk_status("done_hold", ICACHE_DONE);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk_status("back_idle", ICACHE_IDLE);
    end
  endtask

  initial begin
    exp_t e;
    logic [31:0] pa;
    rst = 1'b1;
    idle_inputs();
    s2_physical_addr_i = 32'd0; s2_virtual_addr_i = 32'd0;
    s2_tagv_w0_i = 21'd0; s2_tagv_w1_i = 21'd0; s2_valid0_i = 1'b0; s2_valid1_i = 1'b0;
    s2_data_way0_i = 32'd0; s2_data_way1_i = 32'd0; cacheline_rdata_i = '0;
    for (int i = 0; i < 64; i++) begin
      valid_m[i][0] = 1'b0; valid_m[i][1] = 1'b0;
      tag_m[i][0] = 21'd0;  tag_m[i][1] = 21'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_status("rst_status", ICACHE_IDLE);
    chk1("rst_rd_req", rd_req_o, 1'b0);
    chk1("rst_stall", icache_stall_o, 1'b0);
    chk1("rst_valid", inst_valid_o, 1'b0);
    chk32("rst_inst", inst_o, 32'd0);
    chk1("rst_hit1", s2_hit1_o, 1'b0);
    chk1("rst_rreq", s2_rreq_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Cached miss then hit on the same line, uncached, flush during refill.
    do_txn(32'h0000_1234, 1'b1, 1'b0, -1, 1'b0, 2);
    do_txn(32'h0000_1238, 1'b1, 1'b0, -1, 1'b0, -1);
    do_txn(32'h1FAF_0000, 1'b0, 1'b0, -1, 1'b0, 1);
    do_txn(32'h7F00_0420, 1'b1, 1'b0, 2, 1'b0, 3);

    // Stale SRAM: the word captured on the fresh cycle must be reused.
    pa = 32'h0000_1230;
    e.word = mem_word(pa);
    e.addr = pa ^ 32'hA000_0000;
    @(posedge clk); #1;
    s2_en_i = 1'b1; s2_cache_rreq_i = 1'b1; s2_cached_i = 1'b1;
    s2_physical_addr_i = pa; s2_virtual_addr_i = e.addr;
    present(pa[10:5], pa[4:2], pa[31:11]);
    exp_q.push_back(e);
    @(negedge clk);
    chk1("inst_hit_any", s2_hit1_o | s2_hit2_o, 1'b1);
    @(posedge clk); #1;
    s2_install_i = 1'b1;
    s2_tagv_w0_i = ~s2_tagv_w0_i; s2_tagv_w1_i = ~s2_tagv_w1_i;
    s2_data_way0_i = 32'hBAD0_0000; s2_data_way1_i = 32'hBAD1_1111;
    exp_q.push_back(e);
    @(negedge clk);
    chk1("install_valid", inst_valid_o, 1'b1);
    chk1("install_stall", icache_stall_o, 1'b0);
    @(posedge clk); #1;
    idle_inputs();

    // Randomized traffic over a small set of conflicting lines.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] rpa;
      rpa = {tag_pool[$urandom_range(0, 3)], idx_pool[$urandom_range(0, 1)],
             3'($urandom_range(0, 7)), 2'b00};
      do_txn(rpa, ($urandom_range(0, 9) < 8),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1,
             ($urandom_range(0, 3) == 0), -1);
    end

    // Reset in the middle of a refill; the late rend_i must be ignored.
    pa = {21'h1FFFF, 6'd1, 3'd2, 2'b00};
    @(posedge clk); #1;
    s2_en_i = 1'b1; s2_cache_rreq_i = 1'b1; s2_cached_i = 1'b1;
    s2_physical_addr_i = pa; s2_virtual_addr_i = pa;
    present(pa[10:5], pa[4:2], 21'h0AAAA);
    s2_valid0_i = 1'b0; s2_valid1_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_status("rst_mid_read", ICACHE_READ);
    chk1("rst_mid_req", rd_req_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_status("rst_mid_idle", ICACHE_IDLE);
    chk1("rst_mid_req_drop", rd_req_o, 1'b0);
    @(posedge clk); #1;
    rend_i = 1'b1;
    cacheline_rdata_i = {8{32'hCAFE_F00D}};
    @(negedge clk);
    chk1("late_rend_valid", inst_valid_o, 1'b0);
    @(posedge clk); #1;
    rend_i = 1'b0;
    @(negedge clk);
    chk1("late_rend_valid2", inst_valid_o, 1'b0);
    chk_status("late_rend_status", ICACHE_IDLE);

    repeat (3) @(posedge clk);
    chk32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
